// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg
//   Shared IO constants for the UART receive path: the IO word-address bit
//   that selects the receive register, the receiver FSM state encodings,
//   and the receive shift helper.
//   No ports.
package uart_rx_fifo_pkg;

  localparam int IO_UART_RX_bit = 3;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  // Line order is LSB first, so each new bit enters at the MSB and the
  // byte is aligned once all eight bits have been shifted in.
  function automatic logic [7:0] shift_in_msb(input logic [7:0] sr, input logic b);
    return {b, sr[7:1]};
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// rx_fifo
//   Synchronous FIFO with show-ahead head output.
//   Ports:
//     clk     in   clock, rising edge
//     resetn  in   asynchronous active-low reset (pointers and count)
//     push    in   write wdata (accepted when not full, or full with pop)
//     wdata   in   DATA_W write data
//     pop     in   remove head entry (ignored when empty)
//     head    out  DATA_W oldest entry, valid when !empty
//     empty   out  no entries
//     full    out  DEPTH entries
module rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;
  logic              wr_ok;
  logic              rd_ok;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem[rptr];

  // A push while full is still accepted when a pop frees the slot in the
  // same cycle; wptr equals rptr then, and head is read before the write.
  assign rd_ok = pop && !empty;
  assign wr_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 UART receiver feeding a receive FIFO, read one byte per CPU strobe.
//   Ports:
//     clk         in   system clock, rising edge
//     resetn      in   asynchronous active-low reset
//     RXD         in   serial line, asynchronous, idle high
//     rd_en       in   one-cycle pop request
//     clr_err     in   clears rx_overrun and frame_err
//     rd_data     out  8  byte from the last pop (held when a pop finds none)
//     rd_valid    out  last pop found data
//     rx_valid    out  FIFO non-empty
//     rx_overrun  out  sticky: byte dropped on full FIFO
//     frame_err   out  sticky: stop bit sampled low
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 1_000_000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       RXD,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       frame_err
);

  localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV/2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);

  logic             rxd_p0;
  logic             rxd_p1;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bitn;
  logic [7:0]       shreg;
  logic             push;
  logic             cnt_zero;
  logic             data_tick;
  logic             stop_bad;
  logic             overrun_set;
  logic [7:0]       head;
  logic             empty;
  logic             full;

  // ---- stage p0/p1: two-flop synchroniser on the raw line
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= RXD;
      rxd_p1 <= rxd_p0;
    end
  end

  assign rx_s = rxd_p1;

  // ---- receiver FSM and baud counter on the synchronised line
  assign cnt_zero  = (cnt == '0);
  assign data_tick = (state == ST_DATA) && cnt_zero;
  assign stop_bad  = (state == ST_STOP) && cnt_zero && !rx_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      push  <= 1'b0;
    end else begin
      push <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt   <= CNT_HALF;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end else if (rx_s) begin
            state <= ST_IDLE;
          end else begin
            cnt   <= CNT_FULL;
            bitn  <= '0;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt <= CNT_FULL;
            if (bitn == 3'd7) state <= ST_STOP;
            else              bitn  <= bitn + 3'd1;
          end
        end
        ST_STOP: begin
          // Leaving mid stop bit lets IDLE catch an immediately following start.
          if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end else if (rx_s) begin
            push  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            state <= ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (data_tick) shreg <= shift_in_msb(shreg, rx_s);
  end

  // ---- FIFO and CPU read port
  rx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (shreg),
    .pop    (rd_en),
    .head   (head),
    .empty  (empty),
    .full   (full)
  );

  assign rx_valid    = !empty;
  assign overrun_set = push && full && !rd_en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_valid <= !empty;
        if (!empty) rd_data <= head;
      end
      if (overrun_set)  rx_overrun <= 1'b1;
      else if (clr_err) rx_overrun <= 1'b0;
      if (stop_bad)     frame_err  <= 1'b1;
      else if (clr_err) frame_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo at DIV = 16 with a byte scoreboard.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 16_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int DIV    = 16;

  logic       clk     = 1'b0;
  logic       resetn  = 1'b0;
  logic       RXD     = 1'b1;
  logic       rd_en   = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rx_valid;
  logic       rx_overrun;
  logic       frame_err;

  uart_rx_fifo #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .RXD        (RXD),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rx_valid   (rx_valid),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  logic [7:0] last_rd  = 8'h00;
  int         cyc      = 0;
  int         rise_cyc = -1;
  logic       rv_q     = 1'b0;
  int         start_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !rv_q) rise_cyc = cyc;
    rv_q = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold_bit(input logic v);
    RXD = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic keep);
    if (keep) sb.push_back(b);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop);
  endtask

  task automatic pop_chk(input string tag);
    logic       ev;
    logic [7:0] ed;
    if (sb.size() > 0) begin
      ev      = 1'b1;
      ed      = sb.pop_front();
      last_rd = ed;
    end else begin
      ev = 1'b0;
      ed = last_rd;
    end
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'(ev));
    chk({tag, "_data"},  32'(rd_data),  32'(ed));
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_data"},    32'(rd_data),    32'h0);
    chk({tag, "_rd_valid"},   32'(rd_valid),   32'h0);
    chk({tag, "_rx_valid"},   32'(rx_valid),   32'h0);
    chk({tag, "_rx_overrun"}, 32'(rx_overrun), 32'h0);
    chk({tag, "_frame_err"},  32'(frame_err),  32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte with exact frame-to-readable latency
    start_cyc = cyc;
    send_byte(8'h55, 1'b1, 1'b1);
    chk("single_rise_latency", 32'(rise_cyc - start_cyc), 32'd156);
    chk("single_rx_valid", 32'(rx_valid), 32'h1);
    pop_chk("single_pop");
    chk("single_rx_valid_after", 32'(rx_valid), 32'h0);

    // Back-to-back burst
    send_byte(8'h00, 1'b1, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b1);
    send_byte(8'hA5, 1'b1, 1'b1);
    pop_chk("burst0");
    pop_chk("burst1");
    pop_chk("burst2");
    pop_chk("burst_empty");
    chk("burst_rx_valid", 32'(rx_valid), 32'h0);

    // Overrun: ninth byte dropped
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, i <= 8);
    chk("ovr_flag", 32'(rx_overrun), 32'h1);
    for (int i = 0; i < 8; i++) pop_chk("ovr_pop");
    pop_chk("ovr_empty");
    pulse_clr();
    chk("ovr_cleared", 32'(rx_overrun), 32'h0);

    // Glitch shorter than half a bit
    RXD = 1'b0;
    repeat (4) @(negedge clk);
    RXD = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_rx_valid", 32'(rx_valid), 32'h0);
    chk("glitch_frame_err", 32'(frame_err), 32'h0);

    // Frame error, then a break, then a good byte
    send_byte(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    RXD = 1'b1;
    repeat (5) @(negedge clk);
    chk("ferr_flag", 32'(frame_err), 32'h1);
    chk("ferr_rx_valid", 32'(rx_valid), 32'h0);
    send_byte(8'h12, 1'b1, 1'b1);
    pop_chk("ferr_next");
    pulse_clr();
    chk("ferr_cleared", 32'(frame_err), 32'h0);

    // Full FIFO with a pop landing in the push cycle
    for (int i = 0; i < 8; i++) send_byte(8'hB0 + 8'(i), 1'b1, 1'b1);
    chk("full_rx_valid", 32'(rx_valid), 32'h1);
    fork
      send_byte(8'hC8, 1'b1, 1'b1);
      begin
        repeat (155) @(posedge clk);
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
      end
    join
    begin
      logic [7:0] ed;
      ed      = sb.pop_front();
      last_rd = ed;
      chk("fullpop_valid", 32'(rd_valid), 32'h1);
      chk("fullpop_data", 32'(rd_data), 32'(ed));
    end
    chk("fullpop_no_overrun", 32'(rx_overrun), 32'h0);
    for (int i = 0; i < 8; i++) pop_chk("fullpop_drain");
    pop_chk("fullpop_empty");

    // Asynchronous reset in the middle of a frame
    send_byte(8'hC3, 1'b1, 1'b1);
    send_byte(8'h99, 1'b1, 1'b1);
    pop_chk("pre_reset_pop");
    chk("pre_reset_rx_valid", 32'(rx_valid), 32'h1);
    hold_bit(1'b0);
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b0);
    #2;
    resetn = 1'b0;
    RXD    = 1'b1;
    #1;
    chk_all_zero("midreset");
    sb.delete();
    last_rd = 8'h00;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h7E, 1'b1, 1'b1);
    pop_chk("post_reset");
    pop_chk("post_reset_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
